// File: rtl/wordred_pipe_if.sv
// ---- wordred_pipe_if : input/output stream bundle for wordred_pipe (rev 1.0) ----
`default_nettype none

interface wordred_pipe_if #(
  parameter int Q_WIDTH = 32,
  parameter int TAG_W   = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [2*Q_WIDTH-1:0]   in_c;
  logic [TAG_W-1:0]       in_tag;
  logic                   out_valid;
  logic                   out_ready;
  logic [Q_WIDTH:0]       out_t;
  logic [TAG_W-1:0]       out_tag;

  modport master (
    output in_valid, in_c, in_tag, out_ready,
    input  in_ready, out_valid, out_t, out_tag
  );

  modport slave (
    input  in_valid, in_c, in_tag, out_ready,
    output in_ready, out_valid, out_t, out_tag
  );
endinterface

`default_nettype wire

// File: rtl/wordred_pipe.sv
// ---- wordred_pipe : pipelined word-level Montgomery reduction, out = C*2^(-L*W) mod q (rev 1.0) ----
`default_nettype none

module wordred_pipe #(
  parameter int Q_WIDTH = 32,
  parameter int W       = 13,
  parameter int L       = 3,
  parameter int CORRECT = 1,
  parameter int TAG_W   = 8
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  input  wire logic [Q_WIDTH-W-1:0] qH,
  wordred_pipe_if.slave             bus,
  output logic                      busy
);

  localparam int QH_W = Q_WIDTH - W;
  localparam int SW   = 2 * Q_WIDTH + 1;
  localparam int S    = L + ((CORRECT != 0) ? 1 : 0);

  logic             r_v   [S];
  logic [SW-1:0]    r_d   [S];
  logic [TAG_W-1:0] r_tag [S];

  logic             w_adv;
  logic [SW-1:0]    w_red [L];
  logic [SW-1:0]    w_corr;
  logic             w_unused;

  // One word step: adding m*q clears the low word, so dividing by 2^W is a plain shift.
  function automatic logic [SW-1:0] f_stage(input logic [SW-1:0] t, input logic [QH_W-1:0] qh);
    logic [W-1:0] tl;
    logic [W-1:0] m;
    tl = t[W-1:0];
    m  = -tl;
    return (SW'(m) * SW'(qh)) + (t >> W) + SW'(|tl);
  endfunction

  always_comb begin
    w_red[0] = f_stage(SW'(bus.in_c), qH);
    for (int k = 1; k < L; k++) begin
      w_red[k] = f_stage(r_d[k-1], qH);
    end
  end

  generate
    if (CORRECT != 0) begin : g_corr
      logic [Q_WIDTH-1:0] w_q;
      logic [SW-1:0]      w_qx;
      assign w_q    = {qH, {W{1'b0}}} + Q_WIDTH'(1);
      assign w_qx   = SW'(w_q);
      assign w_corr = (r_d[L-1] >= w_qx) ? (r_d[L-1] - w_qx) : r_d[L-1];
    end else begin : g_nocorr
      assign w_corr = '0;
    end
  endgenerate

  assign w_adv         = ~r_v[S-1] | bus.out_ready;
  assign bus.in_ready  = w_adv;
  assign bus.out_valid = r_v[S-1];
  assign bus.out_t     = r_d[S-1][Q_WIDTH:0];
  assign bus.out_tag   = r_tag[S-1];
  assign w_unused      = ^r_d[S-1][SW-1:Q_WIDTH+1];

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < S; k++) begin
      busy = busy | r_v[k];
    end
  end

  // Single global enable: the whole pipe shifts or the whole pipe holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < S; k++) begin
        r_v[k]   <= 1'b0;
        r_d[k]   <= '0;
        r_tag[k] <= '0;
      end
    end else if (w_adv) begin
      r_v[0]   <= bus.in_valid;
      r_tag[0] <= bus.in_tag;
      for (int k = 1; k < S; k++) begin
        r_v[k]   <= r_v[k-1];
        r_tag[k] <= r_tag[k-1];
      end
      for (int k = 0; k < L; k++) begin
        r_d[k] <= w_red[k];
      end
      if (CORRECT != 0) begin
        r_d[S-1] <= w_corr;
      end
    end
  end

endmodule

`default_nettype wire
